// File: rtl/cve2_if_instr_reg.sv
// IF-to-ID instruction register: classifies fetched words and registers PC/next-PC.
// Define CVE2_IF_SKID_EN for a 2-entry skid buffer with a registered fetch_ready_o.
module cve2_if_instr_reg #(
  parameter bit ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  input  logic        fetch_err_plus2_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic        id_is_compressed_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_next_o,
  output logic        id_err_o,
  output logic        id_err_plus2_o,
  output logic        busy_o
);

  typedef struct packed {
    logic [31:0] instr;
    logic        is_c;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        err;
    logic        err_plus2;
  } entry_t;

  entry_t in_d;
  entry_t main_q;
  entry_t main_d;
  logic   main_v_q;
  logic   main_v_d;
  logic   main_load;
  logic   accept;
  logic   pop;
  logic   in_c;

  assign in_c = fetch_rdata_i[1:0] != 2'b11;

  always_comb begin
    in_d.is_c      = in_c;
    in_d.instr     = in_c ? {16'h0, fetch_rdata_i[15:0]} : fetch_rdata_i;
    in_d.pc        = fetch_addr_i;
    in_d.pc_next   = fetch_addr_i + (in_c ? 32'd2 : 32'd4);
    in_d.err       = fetch_err_i;
    in_d.err_plus2 = fetch_err_plus2_i;
  end

  assign accept     = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign id_valid_o = main_v_q & ~flush_i;
  assign pop        = id_valid_o & id_ready_i;

`ifdef CVE2_IF_SKID_EN
  entry_t skid_q;
  logic   skid_v_q;
  logic   skid_v_d;
  logic   skid_load;

  // Flush overrides the registered ready; the word is dropped anyway.
  assign fetch_ready_o = ~skid_v_q | flush_i;
  assign busy_o        = main_v_q | skid_v_q;

  always_comb begin
    main_v_d  = main_v_q;
    skid_v_d  = skid_v_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_d;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (pop) begin
      if (skid_v_q) begin
        main_load = 1'b1;
        main_d    = skid_q;
        skid_v_d  = 1'b0;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      if (main_v_q) begin
        skid_load = 1'b1;
        skid_v_d  = 1'b1;
      end else begin
        main_load = 1'b1;
        main_v_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_v_q <= 1'b0;
    end else begin
      skid_v_q <= skid_v_d;
    end
  end

  if (ResetAll) begin : g_skid_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        skid_q <= '0;
      end else if (skid_load) begin
        skid_q <= in_d;
      end
    end
  end else begin : g_skid_nrst
    always_ff @(posedge clk_i) begin
      if (skid_load) begin
        skid_q <= in_d;
      end
    end
  end
`else
  assign fetch_ready_o = ~main_v_q | id_ready_i | flush_i;
  assign busy_o        = main_v_q;

  always_comb begin
    main_v_d  = main_v_q;
    main_load = 1'b0;
    main_d    = in_d;
    if (flush_i) begin
      main_v_d = 1'b0;
    end else if (accept) begin
      main_load = 1'b1;
      main_v_d  = 1'b1;
    end else if (pop) begin
      main_v_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_v_q <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
    end
  end

  if (ResetAll) begin : g_main_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        main_q <= '0;
      end else if (main_load) begin
        main_q <= main_d;
      end
    end
  end else begin : g_main_nrst
    always_ff @(posedge clk_i) begin
      if (main_load) begin
        main_q <= main_d;
      end
    end
  end

  assign id_instr_o         = main_q.instr;
  assign id_is_compressed_o = main_q.is_c;
  assign id_pc_o            = main_q.pc;
  assign id_pc_next_o       = main_q.pc_next;
  assign id_err_o           = main_q.err;
  assign id_err_plus2_o     = main_q.err_plus2;

endmodule

// File: doc/cve2_if_instr_reg.md
# cve2_if_instr_reg

Instruction register between the prefetch buffer and the ID stage. It accepts fetched words over a valid/ready handshake and classifies each as compressed (16-bit) or full (32-bit). It computes the sequential next PC and presents a registered instruction to decode. A flush input discards all held entries on branch, mispredict or exception.

## Interface
- `ResetAll`, default 1'b0: when 1, data/PC/error registers reset to 0; when 0, only valid flags are reset.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  discard all held entries (branch/mispredict/exception).
- `fetch_valid_i`  in  1  prefetch word valid.
- `fetch_ready_o`  out  1  block accepts a word this cycle.
- `fetch_rdata_i`  in  32  fetched instruction bits.
- `fetch_addr_i`  in  32  PC of the word (halfword aligned).
- `fetch_err_i`  in  1  fetch bus error.
- `fetch_err_plus2_i`  in  1  error lies in the upper halfword of an unaligned 32-bit instruction.
- `id_valid_o`  out  1  instruction valid to ID.
- `id_ready_i`  in  1  ID consumes the instruction.
- `id_instr_o`  out  32  instruction; compressed instructions are zero-extended from `[15:0]`.
- `id_is_compressed_o`  out  1  `rdata[1:0] != 2'b11`.
- `id_pc_o`  out  32  PC of the instruction.
- `id_pc_next_o`  out  32  `id_pc_o` + 2 (compressed) or + 4; modulo 2^32.
- `id_err_o`  out  1  fetch error.
- `id_err_plus2_o`  out  1  meaningful only when `id_err_o`=1.
- `busy_o`  out  1  any entry valid.

## Operation
- Registered entries: MAIN (drives the `id_*` outputs). With `CVE2_IF_SKID_EN`, a second entry SKID also exists.
- Accept: `fetch_valid_i & fetch_ready_o & ~flush_i`.
- Pop: `id_valid_o & id_ready_i`.
- Classification and next-PC are computed on the input side and stored.
  - The registered outputs carry no combinational path from `fetch_*`.
- Error entries pass data unchanged. `id_is_compressed_o` is still computed from the stored bits; ID must give the error priority.
- Flush:
  - When `flush_i`=1, all valid flags clear at the next edge and any word presented that cycle is dropped.
  - `id_valid_o` is forced 0 combinationally in the flush cycle.
  - `fetch_ready_o`=1 during flush.
- Ordering is strictly FIFO. No entry is ever duplicated or lost except by flush.
- State per entry is valid/empty.
  - Non-skid states: EMPTY, FULL.
  - Skid states: EMPTY, MAIN, MAIN+SKID.
- Transitions in skid mode:
  - EMPTY + accept → MAIN.
  - MAIN + accept, no pop → MAIN+SKID.
  - MAIN + accept + pop → MAIN (new word).
  - MAIN + pop only → EMPTY.
  - MAIN+SKID + pop → MAIN (SKID moves to MAIN).
  - Any state + flush → EMPTY.
- `busy_o` = OR of valid flags.

## Timing
- Reset values:
  - `id_valid_o`=0, `busy_o`=0, `fetch_ready_o`=1.
  - `id_*` data outputs are 0 if `ResetAll`=1, otherwise undefined while `id_valid_o`=0.
- Latency: a word accepted in cycle N is on `id_*` with `id_valid_o`=1 in cycle N+1, provided no older entry is pending.
- Throughput: 1 instruction/cycle sustained while `id_ready_i`=1.
- `id_*` outputs are held stable while `id_valid_o & ~id_ready_i`.
- Reset mid-operation: all entries are discarded immediately, asynchronously.
- Flush and pop in the same cycle: the pop is not performed (`id_valid_o` already forced 0). The entry is discarded.

## Configuration
- `CVE2_IF_SKID_EN` defined:
  - The 2-entry skid buffer is present.
  - `fetch_ready_o` = ~SKID.valid, a registered signal with no path from `id_ready_i`.
  - When full, an ID stall is absorbed with zero bubbles.
- `CVE2_IF_SKID_EN` undefined:
  - Only MAIN exists.
  - `fetch_ready_o` = ~MAIN.valid | `id_ready_i`, a combinational path from ID to prefetch.
  - Functional behaviour and latency are identical; area is smaller.

## Test plan
- Reset then idle:
  - Stimulus: `rst_ni` low then high, `fetch_valid_i`=0.
  - Required: `id_valid_o`=0, `fetch_ready_o`=1, `busy_o`=0.
- Compressed vs full:
  - Stimulus: push `rdata`=0x0000_4501 @ 0x100, then 0x0000_0513 @ 0x102.
  - Required (first): `id_is_compressed_o`=1, `id_instr_o`=0x0000_4501, `id_pc_next_o`=0x102.
  - Required (second): `id_is_compressed_o`=0, `id_pc_next_o`=0x106.
- PC wrap:
  - Stimulus: push 32-bit instruction @ 0xFFFF_FFFC.
  - Required: `id_pc_next_o`=0x0000_0000.
- Back-pressure:
  - Stimulus: stream 4 words (0x13, 0x93, 0x113, 0x193 with `[1:0]`=11), `id_ready_i`=0 for 3 cycles mid-stream.
  - Required with skid: `fetch_ready_o` drops only once both entries are full.
  - Required in both modes: all 4 words delivered in order with no duplicates.
- Flush while full:
  - Stimulus: fill the block, assert `flush_i` for one cycle with `fetch_valid_i`=1.
  - Required: `id_valid_o`=0 that cycle and the next, and the flush-cycle word is dropped.
  - Required: the next pushed word appears 1 cycle after acceptance.
- Error propagation:
  - Stimulus: push `fetch_err_i`=1, `fetch_err_plus2_i`=1 @ 0x202.
  - Required: `id_err_o`=1, `id_err_plus2_o`=1, `id_pc_o`=0x202.
